// File: rtl/nabp_pkg.sv
// Shared definitions for the NABP image-RAM collector: FSM states, default image size, error-bit indices.
package nabp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        CLEAR   = 2'd3
    } nabp_state_t;

    localparam int kDefaultImageAddressLength = 8;
    localparam int kImageSize                 = 2 ** kDefaultImageAddressLength;

    // hs_err layout: {short_frame, overflow, stray}
    localparam int kErrWidth      = 3;
    localparam int kErrStray      = 0;
    localparam int kErrOverflow   = 1;
    localparam int kErrShortFrame = 2;

endpackage

// File: rtl/nabp_image_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port (read-before-write).
module nabp_image_ram
    import nabp_pkg::*;
#(
    parameter int kAddrWidth = kDefaultImageAddressLength,
    parameter int kDataWidth = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [kAddrWidth-1:0] wr_addr,
    input  logic [kDataWidth-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [kAddrWidth-1:0] rd_addr,
    output logic [kDataWidth-1:0] rd_data
);

    logic [kDataWidth-1:0] mem [2**kAddrWidth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/nabp_image_ram_collector.sv
// Receiving end of the NABP image-RAM interface: frame FSM, pixel counter, clear sweep and host readback.
// Optional build macro NABP_IMAGE_RAM_ACCUMULATE_EN: saturating accumulate into RAM through a 2-stage RMW pipe.
module nabp_image_ram_collector
    import nabp_pkg::*;
#(
    parameter int kImageAddressLength = 8,
    parameter int kCacheDataLength    = 16,
    parameter int kCountLength        = kImageAddressLength + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ir_kick,
    input  logic                           ir_done,
    input  logic                           ir_addr_valid,
    input  logic [kImageAddressLength-1:0] ir_addr,
    input  logic [kCacheDataLength-1:0]    ir_val,
    output logic                           ir_enable,
    input  logic                           hs_clear,
    input  logic                           hs_rd_en,
    input  logic [kImageAddressLength-1:0] hs_rd_addr,
    output logic                           hs_rd_valid,
    output logic [kCacheDataLength-1:0]    hs_rd_data,
    output logic                           hs_frame_done,
    output logic                           hs_busy,
    output logic [kCountLength-1:0]        hs_count,
    output logic [kErrWidth-1:0]           hs_err
);

    localparam int                               kDepth     = 2 ** kImageAddressLength;
    localparam logic [kCountLength-1:0]          kCountFull = kCountLength'(kDepth);
    localparam logic [kImageAddressLength-1:0]   kLastAddr  = '1;

    nabp_state_t                    state;
    nabp_state_t                    next_state;
    logic [kImageAddressLength-1:0] clear_addr;
    logic                           transfer;
    logic                           host_window;
    logic                           pipe_busy;
    logic                           rd_accept;
    logic                           clear_accept;
    logic                           count_full;
    logic [kCountLength-1:0]        count_next;
    logic [kErrWidth-1:0]           err_set;
    logic                           rd_pend;

    logic                           ram_wr_en;
    logic [kImageAddressLength-1:0] ram_wr_addr;
    logic [kCacheDataLength-1:0]    ram_wr_data;
    logic                           ram_rd_en;
    logic [kImageAddressLength-1:0] ram_rd_addr;
    logic [kCacheDataLength-1:0]    ram_rd_data;

    assign transfer     = ir_enable && ir_addr_valid;
    assign host_window  = (state == IDLE) || (state == DONE);
    assign rd_accept    = hs_rd_en && host_window && !pipe_busy;
    // A kick in the same cycle as a clear request takes priority; the clear is dropped.
    assign clear_accept = hs_clear && host_window && !pipe_busy && !ir_kick;
    assign hs_busy      = (state == COLLECT) || (state == CLEAR);
    assign count_full   = (hs_count == kCountFull);
    assign count_next   = hs_count + kCountLength'(transfer && !count_full);

    always_comb begin
        err_set                 = '0;
        err_set[kErrStray]      = ((ir_addr_valid || ir_done) && (state != COLLECT))
                                  || (ir_kick && (state == CLEAR));
        err_set[kErrOverflow]   = transfer && count_full;
        err_set[kErrShortFrame] = (state == COLLECT) && ir_done && (count_next < kCountFull);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (ir_kick) begin
                    next_state = COLLECT;
                end else if (clear_accept) begin
                    next_state = CLEAR;
                end
            end
            COLLECT: begin
                if (ir_done) begin
                    next_state = DONE;
                end
            end
            CLEAR: begin
                if (clear_addr == kLastAddr) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ir_enable     <= 1'b0;
            clear_addr    <= '0;
            hs_count      <= '0;
            hs_err        <= '0;
            hs_frame_done <= 1'b0;
            rd_pend       <= 1'b0;
            hs_rd_valid   <= 1'b0;
            hs_rd_data    <= '0;
        end else begin
            state       <= next_state;
            ir_enable   <= (next_state == COLLECT);
            clear_addr  <= (state == CLEAR) ? clear_addr + 1'b1 : '0;
            rd_pend     <= rd_accept;
            hs_rd_valid <= rd_pend;
            if (rd_pend) begin
                hs_rd_data <= ram_rd_data;
            end
            if (host_window && ir_kick) begin
                hs_count      <= '0;
                hs_err        <= err_set;
                hs_frame_done <= 1'b0;
            end else begin
                hs_count <= count_next;
                hs_err   <= hs_err | err_set;
                if ((state == COLLECT) && ir_done) begin
                    hs_frame_done <= 1'b1;
                end else if (clear_accept) begin
                    hs_frame_done <= 1'b0;
                end
            end
        end
    end

`ifdef NABP_IMAGE_RAM_ACCUMULATE_EN
    logic                           s1_valid;
    logic [kImageAddressLength-1:0] s1_addr;
    logic [kCacheDataLength-1:0]    s1_val;
    logic                           fwd_valid;
    logic [kImageAddressLength-1:0] fwd_addr;
    logic [kCacheDataLength-1:0]    fwd_data;
    logic [kCacheDataLength-1:0]    acc_base;
    logic [kCacheDataLength:0]      acc_sum;
    logic [kCacheDataLength-1:0]    acc_result;

    assign pipe_busy = s1_valid;

    // The RAM read issued alongside the previous stage-2 write returns the stale word, so forward it.
    assign acc_base   = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : ram_rd_data;
    assign acc_sum    = {1'b0, acc_base} + {1'b0, s1_val};
    assign acc_result = acc_sum[kCacheDataLength] ? '1 : acc_sum[kCacheDataLength-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            s1_valid  <= transfer;
            fwd_valid <= s1_valid;
        end
        s1_addr  <= ir_addr;
        s1_val   <= ir_val;
        fwd_addr <= s1_addr;
        fwd_data <= acc_result;
    end

    // An accepted transfer already in stage 2 still commits its write even if reset arrives.
    always_comb begin
        ram_wr_en   = s1_valid;
        ram_wr_addr = s1_addr;
        ram_wr_data = acc_result;
        if (state == CLEAR) begin
            ram_wr_en   = reset_n;
            ram_wr_addr = clear_addr;
            ram_wr_data = '0;
        end
        ram_rd_en   = rd_accept;
        ram_rd_addr = hs_rd_addr;
        if (transfer) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = ir_addr;
        end
    end
`else
    assign pipe_busy = 1'b0;

    always_comb begin
        ram_wr_en   = transfer;
        ram_wr_addr = ir_addr;
        ram_wr_data = ir_val;
        if (state == CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clear_addr;
            ram_wr_data = '0;
        end
        ram_wr_en   = ram_wr_en && reset_n;
        ram_rd_en   = rd_accept;
        ram_rd_addr = hs_rd_addr;
    end
`endif

    nabp_image_ram #(
        .kAddrWidth (kImageAddressLength),
        .kDataWidth (kCacheDataLength)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_nabp_image_ram_collector.sv
// Self-checking bench for nabp_image_ram_collector: vector table, directed corner sequences, random vs model.
// Honours NABP_IMAGE_RAM_ACCUMULATE_EN when the design is built with it.
module tb_nabp_image_ram_collector;
    import nabp_pkg::*;

    localparam int kPhIdle    = 0;
    localparam int kPhCollect = 1;
    localparam int kPhDone    = 2;
    localparam int kPhClear   = 3;

    typedef struct packed {
        bit       rst_n;
        bit       kick;
        bit       done;
        bit       av;
        bit [7:0] addr;
        bit [15:0] val;
        bit       clr;
        bit       rden;
        bit [7:0] rdaddr;
    } stim_t;

    typedef struct {
        stim_t     s;
        bit        en;
        bit        busy;
        bit        fdone;
        bit        rdv;
        int        cnt;
        bit [2:0]  err;
        bit [15:0] rdd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ir_kick;
    logic        ir_done;
    logic        ir_addr_valid;
    logic [7:0]  ir_addr;
    logic [15:0] ir_val;
    logic        ir_enable;
    logic        hs_clear;
    logic        hs_rd_en;
    logic [7:0]  hs_rd_addr;
    logic        hs_rd_valid;
    logic [15:0] hs_rd_data;
    logic        hs_frame_done;
    logic        hs_busy;
    logic [8:0]  hs_count;
    logic [2:0]  hs_err;

    int check_count = 0;
    int error_count = 0;

    int       m_phase;
    int       m_count;
    int       m_clear_idx;
    bit [2:0] m_err;
    bit       m_fdone;
    bit       m_rdv;
    bit       m_pend;
    bit       m_pipe;
    int       m_rdd;
    int       m_pend_data;
    int       m_ram [kImageSize];

    always #5 clk = ~clk;

    nabp_image_ram_collector dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ir_kick       (ir_kick),
        .ir_done       (ir_done),
        .ir_addr_valid (ir_addr_valid),
        .ir_addr       (ir_addr),
        .ir_val        (ir_val),
        .ir_enable     (ir_enable),
        .hs_clear      (hs_clear),
        .hs_rd_en      (hs_rd_en),
        .hs_rd_addr    (hs_rd_addr),
        .hs_rd_valid   (hs_rd_valid),
        .hs_rd_data    (hs_rd_data),
        .hs_frame_done (hs_frame_done),
        .hs_busy       (hs_busy),
        .hs_count      (hs_count),
        .hs_err        (hs_err)
    );

    function automatic stim_t idleStim();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t mkStim(bit kick, bit done, bit av, int addr, int val, bit rden, int rdaddr);
        stim_t s = idleStim();
        s.kick   = kick;
        s.done   = done;
        s.av     = av;
        s.addr   = 8'(addr);
        s.val    = 16'(val);
        s.rden   = rden;
        s.rdaddr = 8'(rdaddr);
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, bit en, bit busy, bit fdone, bit rdv, int cnt, bit [2:0] err, int rdd);
        vec_t v;
        v.s = s; v.en = en; v.busy = busy; v.fdone = fdone; v.rdv = rdv;
        v.cnt = cnt; v.err = err; v.rdd = 16'(rdd);
        return v;
    endfunction

    // Reference: one clock edge of the collector, written directly from the frame/clear/readback rules.
    function automatic void modelEdge(stim_t s);
        bit host, tr, stray, rd_ok;
        int sum;
        if (!s.rst_n) begin
            m_phase = kPhIdle; m_count = 0; m_err = '0; m_fdone = 0;
            m_rdv = 0; m_pend = 0; m_pipe = 0;
            return;
        end
        host  = (m_phase == kPhIdle) || (m_phase == kPhDone);
        tr    = (m_phase == kPhCollect) && s.av;
        stray = ((s.av || s.done) && (m_phase != kPhCollect)) || (s.kick && (m_phase == kPhClear));
        rd_ok = s.rden && host && !m_pipe;
        m_rdv = m_pend;
        if (m_pend) m_rdd = m_pend_data;
        m_pend = rd_ok;
        if (rd_ok) m_pend_data = m_ram[s.rdaddr];
        case (m_phase)
            kPhIdle, kPhDone: begin
                if (s.kick) begin
                    m_phase = kPhCollect; m_count = 0; m_err = '0; m_fdone = 0;
                end else if (s.clr && !m_pipe) begin
                    m_phase = kPhClear; m_clear_idx = 0; m_fdone = 0;
                end
            end
            kPhCollect: begin
                if (tr) begin
`ifdef NABP_IMAGE_RAM_ACCUMULATE_EN
                    sum = m_ram[s.addr] + int'(s.val);
                    m_ram[s.addr] = (sum > 65535) ? 65535 : sum;
`else
                    sum = int'(s.val);
                    m_ram[s.addr] = sum;
`endif
                    if (m_count == kImageSize) m_err[1] = 1'b1;
                    else m_count++;
                end
                if (s.done) begin
                    m_phase = kPhDone; m_fdone = 1;
                    if (m_count < kImageSize) m_err[2] = 1'b1;
                end
            end
            default: begin
                m_ram[m_clear_idx] = 0;
                m_clear_idx++;
                if (m_clear_idx == kImageSize) m_phase = kPhIdle;
            end
        endcase
        if (stray) m_err[0] = 1'b1;
`ifdef NABP_IMAGE_RAM_ACCUMULATE_EN
        m_pipe = tr;
`else
        m_pipe = 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".ir_enable"}, int'(ir_enable), int'(m_phase == kPhCollect));
        checkOutput({tag, ".hs_busy"}, int'(hs_busy), int'(m_phase == kPhCollect || m_phase == kPhClear));
        checkOutput({tag, ".hs_count"}, int'(hs_count), m_count);
        checkOutput({tag, ".hs_err"}, int'(hs_err), int'(m_err));
        checkOutput({tag, ".hs_frame_done"}, int'(hs_frame_done), int'(m_fdone));
        checkOutput({tag, ".hs_rd_valid"}, int'(hs_rd_valid), int'(m_rdv));
        if (m_rdv) checkOutput({tag, ".hs_rd_data"}, int'(hs_rd_data), m_rdd);
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        reset_n = s.rst_n; ir_kick = s.kick; ir_done = s.done; ir_addr_valid = s.av;
        ir_addr = s.addr; ir_val = s.val; hs_clear = s.clr; hs_rd_en = s.rden; hs_rd_addr = s.rdaddr;
        @(posedge clk);
        #1;
        modelEdge(s);
        checkModel(tag);
    endtask

    task automatic readCheck(input int addr, input int expected, input string tag);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 1, addr), tag);
        checkOutput({tag, ".valid_early"}, int'(hs_rd_valid), 0);
        applyStimulus(idleStim(), tag);
        checkOutput({tag, ".valid"}, int'(hs_rd_valid), 1);
        checkOutput({tag, ".data"}, int'(hs_rd_data), expected);
    endtask

    task automatic doClear(input string tag, output int busy_cycles);
        stim_t s = idleStim();
        s.clr = 1'b1;
        busy_cycles = 0;
        applyStimulus(s, tag);
        for (int i = 0; i < 300 && hs_busy; i++) begin
            busy_cycles++;
            applyStimulus(idleStim(), tag);
        end
        checkOutput({tag, ".finished"}, int'(hs_busy), 0);
    endtask

    initial begin
        vec_t  vecs[14];
        stim_t s;
        int    n;

        reset_n = 1'b0; ir_kick = 0; ir_done = 0; ir_addr_valid = 0; ir_addr = 0; ir_val = 0;
        hs_clear = 0; hs_rd_en = 0; hs_rd_addr = 0;
        for (int i = 0; i < kImageSize; i++) m_ram[i] = 0;
        m_rdd = 0; m_pend_data = 0; m_clear_idx = 0;

        s = idleStim();
        s.rst_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(s, "reset");
        checkOutput("reset.ir_enable", int'(ir_enable), 0);
        checkOutput("reset.hs_rd_valid", int'(hs_rd_valid), 0);
        checkOutput("reset.hs_rd_data", int'(hs_rd_data), 0);
        checkOutput("reset.hs_frame_done", int'(hs_frame_done), 0);
        checkOutput("reset.hs_busy", int'(hs_busy), 0);
        checkOutput("reset.hs_count", int'(hs_count), 0);
        checkOutput("reset.hs_err", int'(hs_err), 0);

        doClear("clear1", n);
        checkOutput("clear1.busy_cycles", n, 256);
        readCheck(0, 0, "clear1.rd0");
        readCheck(128, 0, "clear1.rd128");
        readCheck(255, 0, "clear1.rd255");

        applyStimulus(mkStim(0, 0, 1, 20, 'h5555, 0, 0), "stray");
        checkOutput("stray.hs_err", int'(hs_err), 'b001);
        readCheck(20, 0, "stray.rd20");

        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "full.kick");
        for (int i = 0; i < 256; i++) applyStimulus(mkStim(0, 0, 1, i, i * 3, 0, 0), "full.xfer");
        applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0), "full.done");
        checkOutput("full.frame_done", int'(hs_frame_done), 1);
        checkOutput("full.count", int'(hs_count), 256);
        checkOutput("full.err", int'(hs_err), 0);
        readCheck(17, 51, "full.rd17");

        doClear("clear2", n);
        vecs[0]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0),         1, 1, 0, 0, 0, 'b000, 0);
        vecs[1]  = mkVec(mkStim(0, 0, 1, 3, 'h1111, 0, 0),    1, 1, 0, 0, 1, 'b000, 0);
        vecs[2]  = mkVec(mkStim(0, 0, 1, 4, 'h2222, 0, 0),    1, 1, 0, 0, 2, 'b000, 0);
        vecs[3]  = mkVec(mkStim(0, 0, 1, 5, 'h3333, 1, 3),    1, 1, 0, 0, 3, 'b000, 0);
        vecs[4]  = mkVec(idleStim(),                          1, 1, 0, 0, 3, 'b000, 0);
        vecs[5]  = mkVec(idleStim(),                          1, 1, 0, 0, 3, 'b000, 0);
        vecs[6]  = mkVec(mkStim(0, 1, 0, 0, 0, 0, 0),         0, 0, 1, 0, 3, 'b100, 0);
        vecs[7]  = mkVec(mkStim(0, 0, 0, 0, 0, 1, 4),         0, 0, 1, 0, 3, 'b100, 0);
        vecs[8]  = mkVec(idleStim(),                          0, 0, 1, 1, 3, 'b100, 'h2222);
        vecs[9]  = mkVec(mkStim(0, 0, 1, 9, 'hBEEF, 0, 0),    0, 0, 1, 0, 3, 'b101, 0);
        vecs[10] = mkVec(mkStim(0, 0, 0, 0, 0, 1, 9),         0, 0, 1, 0, 3, 'b101, 0);
        vecs[11] = mkVec(idleStim(),                          0, 0, 1, 1, 3, 'b101, 0);
        vecs[12] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0),         1, 1, 0, 0, 0, 'b000, 0);
        vecs[13] = mkVec(mkStim(0, 1, 1, 0, 7, 0, 0),         0, 0, 1, 0, 1, 'b100, 0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].s, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.ir_enable", i), int'(ir_enable), int'(vecs[i].en));
            checkOutput($sformatf("vec%0d.hs_busy", i), int'(hs_busy), int'(vecs[i].busy));
            checkOutput($sformatf("vec%0d.frame_done", i), int'(hs_frame_done), int'(vecs[i].fdone));
            checkOutput($sformatf("vec%0d.rd_valid", i), int'(hs_rd_valid), int'(vecs[i].rdv));
            checkOutput($sformatf("vec%0d.hs_count", i), int'(hs_count), vecs[i].cnt);
            checkOutput($sformatf("vec%0d.hs_err", i), int'(hs_err), int'(vecs[i].err));
            if (vecs[i].rdv) checkOutput($sformatf("vec%0d.rd_data", i), int'(hs_rd_data), int'(vecs[i].rdd));
        end

        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "simul.kick");
        for (int i = 0; i < 255; i++) applyStimulus(mkStim(0, 0, 1, i, i, 0, 0), "simul.xfer");
        applyStimulus(mkStim(0, 1, 1, 255, 255, 0, 0), "simul.last");
        checkOutput("simul.count", int'(hs_count), 256);
        checkOutput("simul.err", int'(hs_err), 'b000);
        checkOutput("simul.frame_done", int'(hs_frame_done), 1);

        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "ovf.kick");
        for (int i = 0; i < 257; i++) applyStimulus(mkStim(0, 0, 1, i % 256, i, 0, 0), "ovf.xfer");
        applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0), "ovf.done");
        checkOutput("ovf.count", int'(hs_count), 256);
        checkOutput("ovf.err", int'(hs_err), 'b010);

`ifdef NABP_IMAGE_RAM_ACCUMULATE_EN
        doClear("acc.clear", n);
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "acc.kick1");
        applyStimulus(mkStim(0, 0, 1, 7, 'hFFF0, 0, 0), "acc.f1");
        applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0), "acc.done1");
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "acc.kick2");
        applyStimulus(mkStim(0, 0, 1, 7, 'h0020, 0, 0), "acc.f2");
        applyStimulus(mkStim(0, 0, 1, 5, 1, 0, 0), "acc.b2b1");
        applyStimulus(mkStim(0, 0, 1, 5, 2, 0, 0), "acc.b2b2");
        applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0), "acc.done2");
        applyStimulus(idleStim(), "acc.drain");
        readCheck(7, 'hFFFF, "acc.rd7");
        readCheck(5, 3, "acc.rd5");
`endif

        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), "midclr.idle");
        s = idleStim();
        s.clr = 1'b1;
        applyStimulus(s, "midclr.start");
        for (int i = 0; i < 99; i++) applyStimulus(idleStim(), "midclr.sweep");
        checkOutput("midclr.busy_before", int'(hs_busy), 1);
        s = idleStim();
        s.rst_n = 1'b0;
        applyStimulus(s, "midclr.reset");
        checkOutput("midclr.busy_after", int'(hs_busy), 0);
        applyStimulus(idleStim(), "midclr.release");
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "midclr.kick");
        checkOutput("midclr.ir_enable", int'(ir_enable), 1);
        applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0), "midclr.done");

        for (int i = 0; i < 3000; i++) begin
            s        = idleStim();
            s.rst_n  = ($urandom_range(0, 199) != 0);
            s.kick   = ($urandom_range(0, 39) == 0);
            s.done   = ($urandom_range(0, 29) == 0);
            s.av     = ($urandom_range(0, 9) < 6);
            s.addr   = 8'($urandom);
            s.val    = 16'($urandom);
            s.clr    = ($urandom_range(0, 99) == 0);
            s.rden   = ($urandom_range(0, 4) == 0);
            s.rdaddr = 8'($urandom);
            applyStimulus(s, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
